// File: rtl/usb_pkg.sv
// Shared types for the USB receive path: usb_rx packet/status codes and the
// receive buffer's packet-tracking states.
package usb_pkg;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'b000,
        RX_IN    = 3'b001,
        RX_OUT   = 3'b010,
        RX_DATA  = 3'b011,
        RX_ACK   = 3'b100,
        RX_DONE  = 3'b101,
        RX_ERROR = 3'b110,
        RX_RSVD  = 3'b111   // behaves as RX_IDLE everywhere
    } rx_packet_t;

    typedef enum logic [1:0] {
        BUF_IDLE    = 2'd0,
        BUF_COLLECT = 2'd1,
        BUF_DROP    = 2'd2
    } buf_state_t;

endpackage

// File: rtl/usb_rx_buf_mem.sv
// DEPTH x 8 byte storage for the receive buffer: synchronous write with an
// enable, asynchronous read, contents deliberately left unreset.
module usb_rx_buf_mem #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // Byte write on the enabled edge
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/usb_rx_data_buffer.sv
// Packet-aware receive FIFO behind usb_rx. DATA packet bytes are written
// speculatively past the commit boundary and only become readable when the
// packet ends with DONE; ERROR or an overflow rolls them back.
// Optional build macro: RX_BUF_CRC_STRIP_EN -- drop the trailing CRC16 bytes
// of each packet at commit time.
module usb_rx_data_buffer
    import usb_pkg::*;
#(
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  rx_packet_t       rx_packet,
    input  logic [7:0]       rx_packet_data,
    input  logic             store_rx_packet_data,
    input  logic             get_rx_data,
    input  logic             clear,
    output logic [7:0]       rx_data,
    output logic [PTR_W-1:0] buffer_occupancy,
    output logic             rx_pkt_done,
    output logic             rx_pkt_err,
    output logic             rx_overflow
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_TWO  = PTR_W'(2);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);

    buf_state_t       state_q;
    logic [PTR_W-1:0] r_ptr_q;
    logic [PTR_W-1:0] c_ptr_q;
    logic [PTR_W-1:0] w_ptr_q;
    logic             overflow_q;
    logic             done_q;
    logic             err_q;

    logic             full;
    logic             do_pop;
    logic             do_write;
    logic             drop_byte;
    logic [PTR_W-1:0] occupancy;
    logic [PTR_W-1:0] w_inc;
    logic [PTR_W-1:0] pkt_len;
    logic [PTR_W-1:0] w_strip;
    logic             is_done;
    logic             is_end;

    // Full is measured against the pre-pop read pointer, so a same-cycle pop
    // never frees room for a same-cycle store.
    assign occupancy = c_ptr_q - r_ptr_q;
    assign full      = (w_ptr_q - r_ptr_q) == PTR_FULL;
    assign do_pop    = !clear && get_rx_data && (occupancy != '0);
    assign do_write  = !clear && (state_q == BUF_COLLECT) && store_rx_packet_data && !full;
    assign drop_byte = (state_q == BUF_COLLECT) && store_rx_packet_data && full;

    // A byte stored in the same cycle as DONE/ERROR belongs to the packet, so
    // commit/rollback arithmetic works on the post-write pointer.
    assign w_inc   = do_write ? (w_ptr_q + PTR_ONE) : w_ptr_q;
    assign pkt_len = w_inc - c_ptr_q;
    assign w_strip = w_inc - PTR_TWO;
    assign is_done = (rx_packet == RX_DONE);
    assign is_end  = (rx_packet == RX_DONE) || (rx_packet == RX_ERROR);

    usb_rx_buf_mem #(
        .DEPTH (DEPTH),
        .AW    (PTR_W - 1)
    ) u_mem (
        .clk     (clk),
        .we_i    (do_write),
        .waddr_i (w_ptr_q[PTR_W-2:0]),
        .wdata_i (rx_packet_data),
        .raddr_i (r_ptr_q[PTR_W-2:0]),
        .rdata_o (rx_data)
    );

    // Pointer, packet-state and status flag registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= BUF_IDLE;
            r_ptr_q    <= '0;
            c_ptr_q    <= '0;
            w_ptr_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (clear) begin
            state_q    <= BUF_IDLE;
            r_ptr_q    <= '0;
            c_ptr_q    <= '0;
            w_ptr_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (do_pop) begin
                r_ptr_q <= r_ptr_q + PTR_ONE;
            end
            case (state_q)
                BUF_IDLE: begin
                    if (rx_packet == RX_DATA) begin
                        state_q <= BUF_COLLECT;
                    end
                end
                BUF_COLLECT: begin
                    w_ptr_q <= w_inc;
                    if (drop_byte) begin
                        overflow_q <= 1'b1;
                    end
                    if (is_done && !drop_byte) begin
`ifdef RX_BUF_CRC_STRIP_EN
                        if (pkt_len >= PTR_TWO) begin
                            c_ptr_q <= w_strip;
                            w_ptr_q <= w_strip;
                            done_q  <= 1'b1;
                        end else begin
                            w_ptr_q <= c_ptr_q;
                            err_q   <= 1'b1;
                        end
`else
                        c_ptr_q <= w_inc;
                        done_q  <= 1'b1;
`endif
                        state_q <= BUF_IDLE;
                    end else if (is_end) begin
                        // ERROR, or DONE arriving with a byte dropped this cycle
                        w_ptr_q <= c_ptr_q;
                        err_q   <= 1'b1;
                        state_q <= BUF_IDLE;
                    end else if (drop_byte) begin
                        state_q <= BUF_DROP;
                    end
                end
                BUF_DROP: begin
                    if (is_end) begin
                        w_ptr_q <= c_ptr_q;
                        err_q   <= 1'b1;
                        state_q <= BUF_IDLE;
                    end
                end
                default: state_q <= BUF_IDLE;
            endcase
        end
    end

`ifndef RX_BUF_CRC_STRIP_EN
    logic unused_len;
    assign unused_len = ^{pkt_len, w_strip};
`endif

    assign buffer_occupancy = occupancy;
    assign rx_pkt_done      = done_q;
    assign rx_pkt_err       = err_q;
    assign rx_overflow      = overflow_q;

endmodule

// File: tb/tb_usb_rx_data_buffer.sv
// Self-checking bench for usb_rx_data_buffer: directed scenarios followed by
// randomized packet traffic, all compared against a queue-based model of
// committed and pending bytes.
module tb_usb_rx_data_buffer;
    import usb_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             n_rst;
    rx_packet_t       rx_packet;
    logic [7:0]       rx_packet_data;
    logic             store_rx_packet_data;
    logic             get_rx_data;
    logic             clear;
    logic [7:0]       rx_data;
    logic [PTR_W-1:0] buffer_occupancy;
    logic             rx_pkt_done;
    logic             rx_pkt_err;
    logic             rx_overflow;

    usb_rx_data_buffer #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .rx_packet            (rx_packet),
        .rx_packet_data       (rx_packet_data),
        .store_rx_packet_data (store_rx_packet_data),
        .get_rx_data          (get_rx_data),
        .clear                (clear),
        .rx_data              (rx_data),
        .buffer_occupancy     (buffer_occupancy),
        .rx_pkt_done          (rx_pkt_done),
        .rx_pkt_err           (rx_pkt_err),
        .rx_overflow          (rx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model: readable bytes, bytes of the packet in flight, and
    // whether a packet is being gathered (1) or discarded after overflow (2).
    logic [7:0] mq[$];
    logic [7:0] pq[$];
    logic [7:0] pb[$];
    int         mode = 0;
    bit         exp_done = 0;
    bit         exp_err  = 0;
    bit         exp_ovf  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".occ"},  32'(buffer_occupancy), 32'(mq.size()));
        check({tag, ".done"}, 32'(rx_pkt_done), 32'(exp_done));
        check({tag, ".err"},  32'(rx_pkt_err),  32'(exp_err));
        check({tag, ".ovf"},  32'(rx_overflow), 32'(exp_ovf));
        if (mq.size() > 0) check({tag, ".data"}, 32'(rx_data), 32'(mq[0]));
    endtask

    task automatic model_reset();
        mq.delete(); pq.delete();
        mode = 0; exp_done = 0; exp_err = 0; exp_ovf = 0;
    endtask

    task automatic model_commit();
`ifdef RX_BUF_CRC_STRIP_EN
        if (pq.size() >= 2) begin
            void'(pq.pop_back());
            void'(pq.pop_back());
            foreach (pq[i]) mq.push_back(pq[i]);
            exp_done = 1;
        end else begin
            exp_err = 1;
        end
`else
        foreach (pq[i]) mq.push_back(pq[i]);
        exp_done = 1;
`endif
        pq.delete();
    endtask

    task automatic model(input rx_packet_t p, input bit st, input logic [7:0] b,
                         input bit g, input bit clr);
        bit full;
        bit dropped;
        exp_done = 0;
        exp_err  = 0;
        if (clr) begin
            model_reset();
            return;
        end
        full    = (mq.size() + pq.size()) == DEPTH;
        dropped = 0;
        if (g && mq.size() > 0) void'(mq.pop_front());
        if (mode == 0) begin
            if (p == RX_DATA) mode = 1;
        end else if (mode == 1) begin
            if (st) begin
                if (!full) pq.push_back(b);
                else begin dropped = 1; exp_ovf = 1; end
            end
            if (p == RX_DONE && !dropped) begin
                model_commit(); mode = 0;
            end else if (p == RX_DONE || p == RX_ERROR) begin
                pq.delete(); exp_err = 1; mode = 0;
            end else if (dropped) begin
                mode = 2;
            end
        end else begin
            if (p == RX_DONE || p == RX_ERROR) begin
                pq.delete(); exp_err = 1; mode = 0;
            end
        end
    endtask

    task automatic cycle(input string tag, input rx_packet_t p, input bit st,
                         input logic [7:0] b, input bit g, input bit clr);
        rx_packet            = p;
        store_rx_packet_data = st;
        rx_packet_data       = b;
        get_rx_data          = g;
        clear                = clr;
        @(posedge clk);
        #1;
        model(p, st, b, g, clr);
        check_all(tag);
    endtask

    // DATA token, n stores (bytes from pb first, then random), end code, idle
    task automatic data_pkt(input string tag, input int n, input rx_packet_t endc,
                            input bit popping);
        cycle(tag, RX_DATA, 0, 8'h00, 0, 0);
        for (int i = 0; i < n; i++)
            cycle(tag, RX_DATA, 1, (i < pb.size()) ? pb[i] : 8'($urandom), popping, 0);
        cycle(tag, endc, 0, 8'h00, 0, 0);
        cycle(tag, RX_IDLE, 0, 8'h00, 0, 0);
        pb.delete();
    endtask

    task automatic pop_n(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, RX_IDLE, 0, 8'h00, 1, 0);
    endtask

    initial begin
        n_rst = 1'b0;
        rx_packet = RX_IDLE; rx_packet_data = '0;
        store_rx_packet_data = 0; get_rx_data = 0; clear = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        check_all("reset");

        // 1: two-byte packet committed, then drained
        pb = '{8'hA5, 8'h3C};
        data_pkt("t1", 2, RX_DONE, 0);
`ifndef RX_BUF_CRC_STRIP_EN
        check("t1.occ2", 32'(buffer_occupancy), 32'd2);
        check("t1.head", 32'(rx_data), 32'hA5);
`endif
        pop_n("t1.pop", 2);

        // 2: rollback on ERROR, next packet overwrites the discarded bytes
        pb = '{8'h11, 8'h22, 8'h33};
        data_pkt("t2", 3, RX_ERROR, 0);
        pb = '{8'h44};
        data_pkt("t2b", 1, RX_DONE, 0);
`ifndef RX_BUF_CRC_STRIP_EN
        check("t2.head", 32'(rx_data), 32'h44);
`endif
        pop_n("t2.pop", 1);

        // 3: token packet stores are ignored and end codes give no pulse
        cycle("t3", RX_OUT, 0, 8'h00, 0, 0);
        cycle("t3", RX_OUT, 1, 8'h77, 0, 0);
        cycle("t3", RX_DONE, 0, 8'h00, 0, 0);
        cycle("t3", RX_IDLE, 0, 8'h00, 0, 0);

        // 4: overflow after 63 committed bytes, then clear
        data_pkt("t4a", 63, RX_DONE, 0);
        data_pkt("t4b", 2, RX_DONE, 0);
        check("t4.ovf", 32'(rx_overflow), 32'd1);
        cycle("t4.clr", RX_DATA, 1, 8'h99, 1, 1);
        check("t4.clr_occ", 32'(buffer_occupancy), 32'd0);

        // 5: full buffer, partial drain, new packet stored while popping, wrap
        data_pkt("t5a", 64, RX_DONE, 0);
        pop_n("t5.pop", 10);
        data_pkt("t5b", 5, RX_DONE, 1);
        while (mq.size() > 0) cycle("t5.drain", RX_IDLE, 0, 8'h00, 1, 0);

        // 6: asynchronous reset in the middle of a packet
        cycle("t6", RX_DATA, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) cycle("t6", RX_DATA, 1, 8'(i + 1), 0, 0);
        n_rst = 1'b0;
        #2;
        model_reset();
        check("t6.rst_occ",  32'(buffer_occupancy), 32'd0);
        check("t6.rst_done", 32'(rx_pkt_done), 32'd0);
        check("t6.rst_err",  32'(rx_pkt_err), 32'd0);
        check("t6.rst_ovf",  32'(rx_overflow), 32'd0);
        rx_packet = RX_IDLE; store_rx_packet_data = 0;
        #2;
        n_rst = 1'b1;
        pb = '{8'h5A};
        data_pkt("t6b", 1, RX_DONE, 0);
        pop_n("t6.pop", 1);
        pb = '{8'h01, 8'hFE, 8'hED};
        data_pkt("t6c", 3, RX_DONE, 0);
`ifdef RX_BUF_CRC_STRIP_EN
        check("t6.crc_occ", 32'(buffer_occupancy), 32'd1);
        check("t6.crc_head", 32'(rx_data), 32'h01);
`endif
        cycle("t6.clr", RX_IDLE, 0, 8'h00, 0, 1);

        // Random traffic
        for (int p = 0; p < 150; p++) begin
            int kind;
            kind = int'($urandom_range(0, 19));
            if (kind == 0) begin
                cycle("rnd.clr", rx_packet_t'($urandom_range(0, 7)), 1, 8'($urandom), 1, 1);
            end else if (kind < 3) begin
                cycle("rnd.tok", (kind == 1) ? RX_IN : RX_OUT, 0, 8'h00, 0, 0);
                cycle("rnd.tok", RX_OUT, 1, 8'($urandom), $urandom_range(0, 1) == 1, 0);
                cycle("rnd.tok", ($urandom_range(0, 1) == 1) ? RX_DONE : RX_ERROR, 0, 8'h00, 0, 0);
            end else begin
                int n;
                n = int'($urandom_range(0, 12));
                cycle("rnd.pkt", RX_DATA, 0, 8'h00, $urandom_range(0, 99) < 40, 0);
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 3) == 0)
                        cycle("rnd.gap", RX_DATA, 0, 8'h00, $urandom_range(0, 99) < 40, 0);
                    cycle("rnd.st", RX_DATA, 1, 8'($urandom), $urandom_range(0, 99) < 40, 0);
                end
                cycle("rnd.end", ($urandom_range(0, 3) == 0) ? RX_ERROR : RX_DONE,
                      $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 99) < 40, 0);
            end
            repeat ($urandom_range(0, 3))
                cycle("rnd.idle", RX_IDLE, 0, 8'h00, $urandom_range(0, 99) < 50, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
